// File: rtl/line_feeder_pkg.sv
// Shared types for the line feeder: FSM state and counter sizing.
package line_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREFILL,
    STREAM,
    DRAIN
  } state_t;

  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned DEF_CNTW  = $clog2(DEF_DEPTH) + 1;

  function automatic int unsigned cnt_w(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/line_feeder_fifo.sv
// Small prefetch FIFO with synchronous flush and occupancy count.
module sync_fifo_small
  import line_feeder_pkg::*;
#(
  parameter int DATAW = 4,
  parameter int DEPTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      push_i,
  input  logic [DATAW-1:0]          wdata_i,
  input  logic                      pop_i,
  output logic [DATAW-1:0]          rdata_o,
  output logic [cnt_w(DEPTH)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [DATAW-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/line_feeder.sv
// Fetches one source row per line start and streams it as a gap-free burst.
module line_feeder
  import line_feeder_pkg::*;
#(
  parameter int DATAW      = 4,
  parameter int LEN        = 640,
  parameter int LINES      = 480,
  parameter int SCALEW     = 6,
  parameter int ADDRW      = 19,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              frame_sys,
  input  logic              line_sys,
  input  logic [SCALEW-1:0] scale_v,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDRW-1:0]  mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATAW-1:0]  mem_rsp_data,
  output logic              en_in,
  output logic [DATAW-1:0]  data_out,
  output logic              busy,
  output logic              underrun
);

  localparam int CW   = cnt_w(FIFO_DEPTH);
  localparam int COLW = $clog2(LEN + 1);
  localparam logic [ADDRW-1:0] LAST_BASE = ADDRW'((LINES - 1) * LEN);
  localparam logic [ADDRW-1:0] LEN_A     = ADDRW'(LEN);
  localparam logic [COLW-1:0]  LEN_C     = COLW'(LEN);
  localparam logic [CW:0]      CDEPTH    = (CW + 1)'(FIFO_DEPTH);

  state_t            state_q;
  logic [ADDRW-1:0]  row_base_q;
  logic [ADDRW-1:0]  base_q;
  logic [SCALEW-1:0] vcnt_q;
  logic [COLW-1:0]   col_q;
  logic [COLW-1:0]   slot_q;
  logic [CW-1:0]     out_q;
  logic              pend_q;
  logic              en_q;
  logic              und_q;
  logic [DATAW-1:0]  dout_q;

  logic [CW-1:0]     out_d;
  logic [CW-1:0]     fcount;
  logic [CW:0]       inflight;
  logic [DATAW-1:0]  fdata;
  logic              fetching;
  logic              req_hs;
  logic              abort;
  logic              stream_end;
  logic              flush;
  logic              push;
  logic              pop;
  logic [ADDRW-1:0]  rb_cur;
  logic [ADDRW-1:0]  rb_d;
  logic [SCALEW-1:0] vc_cur;
  logic [SCALEW-1:0] vc_d;
  logic [SCALEW-1:0] smax;

  // Credit: never request more than the FIFO can still absorb.
  assign fetching      = (state_q == PREFILL) || (state_q == STREAM);
  assign inflight      = {1'b0, out_q} + {1'b0, fcount};
  assign mem_req_valid = fetching && (col_q < LEN_C) && (inflight < CDEPTH);
  assign mem_req_addr  = base_q + ADDRW'(col_q);
  assign req_hs        = mem_req_valid && mem_req_ready;

  assign abort      = (line_sys || frame_sys) && (state_q != IDLE);
  assign stream_end = (state_q == STREAM) && (slot_q == LEN_C);
  assign flush      = abort || stream_end;
  assign push       = mem_rsp_valid && (state_q != DRAIN) && !flush;
  assign pop        = (state_q == STREAM) && (slot_q != LEN_C) && !abort;
  assign out_d      = out_q + CW'(req_hs) - CW'(mem_rsp_valid);

  always_comb begin
    rb_cur = frame_sys ? '0 : row_base_q;
    vc_cur = frame_sys ? '0 : vcnt_q;
    smax   = (scale_v == '0) ? SCALEW'(1) : scale_v;
    rb_d   = rb_cur;
    vc_d   = vc_cur + 1'b1;
    if (vc_cur >= smax - 1'b1) begin
      vc_d = '0;
      if (rb_cur != LAST_BASE) rb_d = rb_cur + LEN_A;
    end
  end

  sync_fifo_small #(
    .DATAW (DATAW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_sys),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i (mem_rsp_data),
    .pop_i   (pop),
    .rdata_o (fdata),
    .count_o (fcount)
  );

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_base_q <= '0;
      base_q     <= '0;
      vcnt_q     <= '0;
      col_q      <= '0;
      slot_q     <= '0;
      out_q      <= '0;
      pend_q     <= 1'b0;
      en_q       <= 1'b0;
      und_q      <= 1'b0;
      dout_q     <= '0;
    end else begin
      out_q <= out_d;
      en_q  <= 1'b0;
      if (frame_sys) begin
        row_base_q <= '0;
        vcnt_q     <= '0;
        und_q      <= 1'b0;
      end
      if (line_sys) begin
        base_q     <= rb_cur;
        col_q      <= '0;
        row_base_q <= rb_d;
        vcnt_q     <= vc_d;
      end else if (req_hs) begin
        col_q <= col_q + 1'b1;
      end
      if (pop) begin
        dout_q <= (fcount == '0) ? '0 : fdata;
        slot_q <= slot_q + 1'b1;
        if (fcount == '0) und_q <= 1'b1;
      end
      if (flush) dout_q <= '0;
      if (abort) begin
        pend_q <= line_sys;
        if (out_d != '0)   state_q <= DRAIN;
        else if (line_sys) state_q <= PREFILL;
        else               state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (line_sys) state_q <= PREFILL;
          PREFILL: begin
            if ((fcount == CW'(FIFO_DEPTH)) ||
                ((col_q == LEN_C) && (out_q == '0))) begin
              state_q <= STREAM;
              en_q    <= 1'b1;
              slot_q  <= '0;
            end
          end
          STREAM: begin
            if (stream_end) begin
              pend_q  <= 1'b0;
              state_q <= (out_d != '0) ? DRAIN : IDLE;
            end
          end
          DRAIN: begin
            if (out_d == '0) state_q <= pend_q ? PREFILL : IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign en_in    = en_q;
  assign data_out = dout_q;
  assign busy     = (state_q != IDLE);
  assign underrun = und_q;

endmodule

// File: tb/tb_line_feeder.sv
// Scoreboard bench for line_feeder with a latency-programmable memory model.
module tb_line_feeder;

  localparam int DATAW  = 4;
  localparam int LEN    = 16;
  localparam int LINES  = 4;
  localparam int SCALEW = 6;
  localparam int ADDRW  = 19;
  localparam int DEPTH  = 8;

  localparam int K_EXACT = 0;
  localparam int K_UNDER = 1;
  localparam int K_ABORT = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              frame_sys = 1'b0;
  logic              line_sys = 1'b0;
  logic [SCALEW-1:0] scale_v = 1;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic [ADDRW-1:0]  mem_req_addr;
  logic              mem_rsp_valid = 1'b0;
  logic [DATAW-1:0]  mem_rsp_data = '0;
  logic              en_in;
  logic [DATAW-1:0]  data_out;
  logic              busy;
  logic              underrun;

  line_feeder #(
    .DATAW(DATAW), .LEN(LEN), .LINES(LINES),
    .SCALEW(SCALEW), .ADDRW(ADDRW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_sys(clk), .rst_n(rst_n),
    .frame_sys(frame_sys), .line_sys(line_sys), .scale_v(scale_v),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .en_in(en_in), .data_out(data_out),
    .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct { int row; int kind; } line_t;
  typedef struct { int due; logic [DATAW-1:0] d; } rsp_t;

  line_t exp_q[$];
  rsp_t  rsp_q[$];
  int    hs_log[$];
  int    lat = 1;
  int    stall_at = -1;
  int    stall_left = 0;
  int    hs_cnt = 0;
  bit    prev_stall = 0;
  int    prev_addr = 0;

  // Pixel memory content: word = low nibble + next nibble of the address.
  function automatic logic [DATAW-1:0] mem_word(logic [ADDRW-1:0] a);
    return a[3:0] + a[7:4];
  endfunction

  always @(negedge clk) begin
    if (prev_stall) begin
      check("req_hold_valid", int'(mem_req_valid), 1);
      check("req_hold_addr", int'(mem_req_addr), prev_addr);
    end
    if (stall_left > 0) begin
      mem_req_ready = 1'b0;
      stall_left--;
    end else if (stall_at >= 0 && hs_cnt == stall_at) begin
      mem_req_ready = 1'b0;
      stall_left = 4;
      stall_at = -1;
    end else begin
      mem_req_ready = 1'b1;
    end
    prev_stall = mem_req_valid && !mem_req_ready;
    prev_addr  = int'(mem_req_addr);
    if (mem_req_valid && mem_req_ready) begin
      hs_cnt++;
      hs_log.push_back(int'(mem_req_addr));
      rsp_q.push_back('{cyc + lat, mem_word(mem_req_addr)});
      check("credit", int'(rsp_q.size() <= DEPTH), 1);
    end
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = rsp_q[0].d;
      void'(rsp_q.pop_front());
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
  end

  // Monitor: one expected line per en_in pulse.
  bit    act = 0;
  int    slot = 0;
  line_t cur;

  always @(posedge clk) begin
    #1;
    if (act) begin
      if (line_sys || frame_sys) begin
        check("abort_dout", int'(data_out), 0);
        check("abort_kind", cur.kind, K_ABORT);
        act = 0;
      end else if (slot < LEN) begin
        if (cur.kind == K_UNDER && slot >= DEPTH) begin
          if (slot == DEPTH) check("under_slot", int'(data_out), 0);
        end else begin
          check($sformatf("pix_r%0d_c%0d", cur.row, slot),
                int'(data_out), (cur.row + slot) % 16);
        end
        slot++;
      end else begin
        check("burst_end", int'(data_out), 0);
        if (cur.kind == K_UNDER) check("underrun_flag", int'(underrun), 1);
        act = 0;
      end
    end
    if (en_in) begin
      if (act || exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL en_in: unexpected burst start at cycle %0d", cyc);
        act = 0;
      end else begin
        cur  = exp_q.pop_front();
        act  = 1;
        slot = 0;
      end
    end
  end

  int lineidx = 0;
  int fscale = 1;

  function automatic int row_of(int idx, int sc);
    int s;
    int r;
    s = (sc == 0) ? 1 : sc;
    r = idx / s;
    return (r > LINES - 1) ? LINES - 1 : r;
  endfunction

  task automatic set_scale(int s);
    scale_v = SCALEW'(s);
    fscale = s;
  endtask

  task automatic pulse(bit f, bit l);
    @(negedge clk);
    frame_sys = f;
    line_sys  = l;
    @(negedge clk);
    frame_sys = 1'b0;
    line_sys  = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles", budget);
    end
  endtask

  task automatic queue_line(bit fr, int kind, output int r);
    if (fr) lineidx = 0;
    r = row_of(lineidx, fscale);
    exp_q.push_back('{r, kind});
    lineidx++;
  endtask

  task automatic run_line(bit fr, int kind, bit chk_base);
    int r;
    queue_line(fr, kind, r);
    hs_log.delete();
    pulse(fr, 1'b1);
    wait_idle(400);
    if (chk_base)
      check("base_addr", (hs_log.size() > 0) ? hs_log[0] : -1, r * LEN);
  endtask

  initial begin
    int r;
    int n;
    repeat (3) @(negedge clk);
    check("rst_en_in", int'(en_in), 0);
    check("rst_data_out", int'(data_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_req_valid", int'(mem_req_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic line with single-cycle memory.
    set_scale(1);
    run_line(1'b1, K_EXACT, 1'b1);
    check("t1_req_count", hs_log.size(), LEN);
    for (int i = 0; i < LEN && i < hs_log.size(); i++)
      check($sformatf("t1_addr%0d", i), hs_log[i], i);

    // Vertical repeat of three.
    set_scale(3);
    run_line(1'b1, K_EXACT, 1'b1);
    for (int i = 0; i < 6; i++) run_line(1'b0, K_EXACT, 1'b1);

    // Request port stalls for five cycles while prefetching.
    set_scale(1);
    run_line(1'b1, K_EXACT, 1'b1);
    stall_at = hs_cnt + 4;
    run_line(1'b0, K_EXACT, 1'b1);

    // Long latency starves the stream.
    lat = 20;
    run_line(1'b0, K_UNDER, 1'b1);
    check("t4_underrun_set", int'(underrun), 1);
    lat = 1;
    pulse(1'b1, 1'b0);
    lineidx = 0;
    check("t4_underrun_clr", int'(underrun), 0);

    // Abort during the stream with responses still in flight.
    lat = 3;
    run_line(1'b0, K_EXACT, 1'b1);
    queue_line(1'b0, K_ABORT, r);
    pulse(1'b0, 1'b1);
    n = 0;
    while (!en_in && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_en_seen", int'(en_in), 1);
    repeat (4) @(negedge clk);
    run_line(1'b0, K_EXACT, 1'b0);
    lat = 1;

    // Scale zero, coincident frame and line, row saturation.
    set_scale(0);
    run_line(1'b1, K_EXACT, 1'b1);
    for (int i = 0; i < 5; i++) run_line(1'b0, K_EXACT, 1'b1);

    // Random frames.
    for (int f = 0; f < 4; f++) begin
      set_scale(int'($urandom_range(0, 3)));
      lat = int'($urandom_range(1, 6));
      run_line(1'b1, K_EXACT, 1'b1);
      n = int'($urandom_range(3, 7));
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 4)) @(negedge clk);
        run_line(1'b0, K_EXACT, 1'b1);
      end
    end

    repeat (5) @(negedge clk);
    check("lines_all_streamed", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
